axim_stream_mem_model: RTL

Synthesizable, parametrised responder for the AXIM control and stream interface of the vector memory subsystem. It replaces ad-hoc bench drivers with a RAM-backed model. Reads stream stored words on rd_* after a programmable latency. Writes accept wr_* beats into the RAM. Optional LFSR back-pressure exercises the mem_subsys handshakes in simulation and on FPGA.

---
 rtl/axim_stream_mem_model.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axim_stream_mem_model.sv
// ---------------------------------------------------------------------------
// axim_stream_mem_model
//
// RAM-backed responder for the AXIM control + stream interface of the vector
// memory subsystem. A read command streams stored words on rd_* after a
// programmable latency; a write command accepts wr_* beats into the RAM and
// pulses ctrl_wdone_o a fixed number of cycles after the final beat. An
// optional 16-bit LFSR throttles rd_tvalid_o / wr_tready_o to exercise the
// handshakes of the subsystem under test.
//
// Ports:
//   clk, rstn             clock; asynchronous active-high reset
//   stall_en_i            1 = LFSR-driven stalls on rd_tvalid_o / wr_tready_o
//   ctrl_raddr_offset_i   read start byte address
//   ctrl_rxfer_size_i     read length in bytes
//   ctrl_rstart_i         read start pulse (ignored while read side busy)
//   ctrl_rdone_o          read done, one-cycle pulse
//   rd_tdata_o/tvalid_o/tready_i/tlast_o   read stream
//   ctrl_waddr_offset_i   write start byte address
//   ctrl_wxfer_size_i     write length in bytes
//   ctrl_wstart_i         write start pulse (ignored while write side busy)
//   ctrl_wdone_o          write done, one-cycle pulse
//   wr_tdata_i/tvalid_i/tready_o           write stream
//   err_o                 sticky protocol error flag
//
// Build option: define AXIM_MODEL_ERR_CHK_EN to generate the protocol checker
// behind err_o. Without it err_o is tied low.
// ---------------------------------------------------------------------------
module axim_stream_mem_model #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          XFER_SIZE_WIDTH = 32,
    parameter int          MEM_DEPTH       = 1024,
    parameter int          RD_LATENCY      = 4,
    parameter int          WDONE_DELAY     = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       stall_en_i,
    input  logic [ADDR_WIDTH-1:0]      ctrl_raddr_offset_i,
    input  logic [XFER_SIZE_WIDTH-1:0] ctrl_rxfer_size_i,
    input  logic                       ctrl_rstart_i,
    output logic                       ctrl_rdone_o,
    output logic [DATA_WIDTH-1:0]      rd_tdata_o,
    output logic                       rd_tvalid_o,
    input  logic                       rd_tready_i,
    output logic                       rd_tlast_o,
    input  logic [ADDR_WIDTH-1:0]      ctrl_waddr_offset_i,
    input  logic [XFER_SIZE_WIDTH-1:0] ctrl_wxfer_size_i,
    input  logic                       ctrl_wstart_i,
    output logic                       ctrl_wdone_o,
    input  logic [DATA_WIDTH-1:0]      wr_tdata_i,
    input  logic                       wr_tvalid_i,
    output logic                       wr_tready_o,
    output logic                       err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int XW    = XFER_SIZE_WIDTH;
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int DRN_W = (WDONE_DELAY > 1) ? $clog2(WDONE_DELAY) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((WDONE_DELAY > 0) ? WDONE_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        R_IDLE,
        R_LAT,
        R_STREAM,
        R_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STREAM,
        W_DRAIN,
        W_DONE
    } wr_state_t;

    // With no drain delay the write side skips W_DRAIN entirely.
    localparam wr_state_t W_AFTER = (WDONE_DELAY == 0) ? W_DONE : W_DRAIN;

    // Byte offset -> RAM word index; low bits below BYTES are dropped and the
    // index wraps naturally because MEM_DEPTH is a power of two.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] off);
        return IDX_W'(off >> BSH);
    endfunction

    // ceil(size / BYTES), computed one bit wider so the round-up cannot wrap.
    function automatic logic [XW-1:0] beat_cnt(input logic [XW-1:0] sz);
        logic [XW:0] rnd;
        rnd = {1'b0, sz} + (XW+1)'(BYTES - 1);
        return XW'(rnd >> BSH);
    endfunction

    // -----------------------------------------------------------------------
    // Stall LFSR: Fibonacci, taps 16,14,13,11, free-running.
    // -----------------------------------------------------------------------
    logic [15:0] lfsr_q, lfsr_d;
    logic        stall;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = stall_en_i & lfsr_q[0];

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q;

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    rd_state_t        r_state_q, r_state_d;
    logic [LAT_W-1:0] r_cnt_q, r_cnt_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [XW-1:0]    r_rem_q, r_rem_d;   // beats not yet handshaken
    logic [XW-1:0]    r_rem_nxt;
    logic             r_vld_q, r_vld_d;
    logic             r_load;             // fetch next word into r_data_q
    logic             rd_hs;

    assign rd_hs = r_vld_q & rd_tready_i;

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_rem_d   = r_rem_q;
        r_vld_d   = r_vld_q;
        r_rem_nxt = r_rem_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ctrl_rstart_i) begin
                    r_idx_d   = word_idx(ctrl_raddr_offset_i);
                    r_rem_d   = beat_cnt(ctrl_rxfer_size_i);
                    r_cnt_d   = '0;
                    r_state_d = R_LAT;
                end
            end
            R_LAT: begin
                if (r_cnt_q == LAT_LAST) begin
                    r_state_d = (r_rem_q == '0) ? R_DONE : R_STREAM;
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end
            R_STREAM: begin
                r_rem_nxt = rd_hs ? r_rem_q - 1'b1 : r_rem_q;
                r_rem_d   = r_rem_nxt;
                if (rd_hs) begin
                    r_vld_d = 1'b0;
                end
                // A new beat is only launched when the slot is free (empty or
                // draining this cycle) and the LFSR is not stalling; a beat
                // already on the bus is never withdrawn.
                if ((!r_vld_q || rd_hs) && (r_rem_nxt != '0) && !stall) begin
                    r_load  = 1'b1;
                    r_vld_d = 1'b1;
                    r_idx_d = r_idx_q + 1'b1;
                end
                if (r_rem_nxt == '0) begin
                    r_state_d = R_DONE;
                end
            end
            R_DONE: begin
                r_state_d = R_IDLE;
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    assign rd_tvalid_o  = r_vld_q;
    assign rd_tdata_o   = r_vld_q ? r_data_q : '0;
    assign rd_tlast_o   = r_vld_q & (r_rem_q == XW'(1));
    assign ctrl_rdone_o = (r_state_q == R_DONE);

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    wr_state_t        w_state_q, w_state_d;
    logic [DRN_W-1:0] w_cnt_q, w_cnt_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [XW-1:0]    w_rem_q, w_rem_d;
    logic             w_wr;

    assign wr_tready_o = (w_state_q == W_STREAM) & ~stall;
    assign w_wr        = wr_tready_o & wr_tvalid_i;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_rem_d   = w_rem_q;
        case (w_state_q)
            W_IDLE: begin
                if (ctrl_wstart_i) begin
                    w_idx_d   = word_idx(ctrl_waddr_offset_i);
                    w_rem_d   = beat_cnt(ctrl_wxfer_size_i);
                    w_cnt_d   = '0;
                    w_state_d = (beat_cnt(ctrl_wxfer_size_i) == '0) ? W_AFTER : W_STREAM;
                end
            end
            W_STREAM: begin
                if (w_wr) begin
                    w_idx_d = w_idx_q + 1'b1;
                    w_rem_d = w_rem_q - 1'b1;
                    if (w_rem_q == XW'(1)) begin
                        w_cnt_d   = '0;
                        w_state_d = W_AFTER;
                    end
                end
            end
            W_DRAIN: begin
                if (w_cnt_q == DRN_LAST) begin
                    w_state_d = W_DONE;
                end else begin
                    w_cnt_d = w_cnt_q + 1'b1;
                end
            end
            W_DONE: begin
                w_state_d = W_IDLE;
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    assign ctrl_wdone_o = (w_state_q == W_DONE);

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            lfsr_q    <= LFSR_SEED;
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_rem_q   <= '0;
            r_vld_q   <= 1'b0;
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            w_rem_q   <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_rem_q   <= r_rem_d;
            r_vld_q   <= r_vld_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_rem_q   <= w_rem_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAM: synchronous read-first dual port. Read and write at the same edge
    // to the same word return the old contents; the read register is held
    // between loads so a stalled beat keeps its data.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem[w_idx_q] <= wr_tdata_i;
        end
        if (r_load) begin
            r_data_q <= mem[r_idx_q];
        end
    end

    // -----------------------------------------------------------------------
    // Optional protocol checker
    // -----------------------------------------------------------------------
`ifdef AXIM_MODEL_ERR_CHK_EN
    logic err_q, err_d;
    logic err_set;

    always_comb begin
        err_set = (ctrl_rstart_i & (r_state_q != R_IDLE))
                | (ctrl_wstart_i & (w_state_q != W_IDLE))
                | (ctrl_rstart_i & (|ctrl_raddr_offset_i[BSH-1:0]))
                | (ctrl_rstart_i & (|ctrl_rxfer_size_i[BSH-1:0]))
                | (ctrl_wstart_i & (|ctrl_waddr_offset_i[BSH-1:0]))
                | (ctrl_wstart_i & (|ctrl_wxfer_size_i[BSH-1:0]))
                | (wr_tvalid_i & (w_state_q == W_IDLE));
        err_d = err_q | err_set;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
